oled_text_sched: RTL

//  Sequences oled_control for text display. Holds a ROWS x COLS character buffer, arbitrates

---
 rtl/oled_text_sched.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/oled_text_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// oled_text_sched
//
// Text-mode front end for oled_control. Holds a ROWS x COLS character buffer,
// accepts cell writes from two client ports (A, B) with round-robin
// arbitration, and streams whole frames to oled_control. Each frame covers
// cells 0..N-1 in raster order, one character per send_data/send_done
// handshake. A frame is never cut short, so oled_control's 128-column/page
// wrap stays aligned with the buffer.
//
// Optional feature (compile-time macro OLED_SCHED_CLEAR_EN):
//   defined     -> adds input clear_req; a one-cycle pulse blanks every cell,
//                  marks the buffer dirty and blocks both write ports that cycle.
//   not defined -> no clear_req port; the buffer is blanked only by reset_n.
//
// Ports:
//   clock            in   system clock
//   reset_n          in   asynchronous active-low reset
//   clear_req        in   (OLED_SCHED_CLEAR_EN only) blank the whole buffer
//   a_wr_valid       in   client A write request
//   a_wr_addr        in   client A cell index (row*COLS+col), AW bits
//   a_wr_char        in   client A character code, CHAR_W bits
//   a_wr_ready       out  client A write accepted this cycle
//   b_wr_*           --   same as A for client B
//   send_data        out  character presented to oled_control
//   send_data_valid  out  request to oled_control
//   send_done        in   oled_control finished the current character
//   busy             out  a frame is in progress
//   frame_done       out  one-cycle pulse after the last cell of a frame
// -----------------------------------------------------------------------------
module oled_text_sched #(
    parameter int                CHAR_W     = 7,
    parameter int                COLS       = 16,
    parameter int                ROWS       = 4,
    parameter logic [CHAR_W-1:0] BLANK_CHAR = 7'h20,
    localparam int               N          = ROWS * COLS,
    localparam int               AW         = $clog2(N)
) (
    input  logic              clock,
    input  logic              reset_n,
`ifdef OLED_SCHED_CLEAR_EN
    input  logic              clear_req,
`endif
    input  logic              a_wr_valid,
    input  logic [AW-1:0]     a_wr_addr,
    input  logic [CHAR_W-1:0] a_wr_char,
    output logic              a_wr_ready,
    input  logic              b_wr_valid,
    input  logic [AW-1:0]     b_wr_addr,
    input  logic [CHAR_W-1:0] b_wr_char,
    output logic              b_wr_ready,
    output logic [CHAR_W-1:0] send_data,
    output logic              send_data_valid,
    input  logic              send_done,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CHAR_W-1:0] r_buf [N];
    logic              r_dirty;
    logic              r_last_b;     // 1: last grant went to B
    logic [AW-1:0]     r_idx;

    logic              w_clear;
    logic              w_a_grant;
    logic              w_b_grant;
    logic              w_a_inr;
    logic              w_b_inr;
    logic              w_last_idx;

`ifdef OLED_SCHED_CLEAR_EN
    assign w_clear = clear_req;
`else
    assign w_clear = 1'b0;
`endif

    // Round-robin: when both clients ask, the side that did not win last
    // time is served. A clear in the same cycle blocks both ports.
    assign w_a_grant = !w_clear && a_wr_valid && (!b_wr_valid ||  r_last_b);
    assign w_b_grant = !w_clear && b_wr_valid && (!a_wr_valid || !r_last_b);

    assign a_wr_ready = w_a_grant;
    assign b_wr_ready = w_b_grant;

    // Out-of-range addresses are acknowledged but never stored.
    assign w_a_inr    = (32'(a_wr_addr) < N);
    assign w_b_inr    = (32'(b_wr_addr) < N);
    assign w_last_idx = (r_idx == AW'(N - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_b <= 1'b1;
        end else if (w_a_grant) begin
            r_last_b <= 1'b0;
        end else if (w_b_grant) begin
            r_last_b <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= BLANK_CHAR;
            end
        end else if (w_clear) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= BLANK_CHAR;
            end
        end else begin
            if (w_a_grant && w_a_inr) begin
                r_buf[a_wr_addr] <= a_wr_char;
            end
            if (w_b_grant && w_b_inr) begin
                r_buf[b_wr_addr] <= b_wr_char;
            end
        end
    end

    // A write landing in the same cycle that IDLE consumes the dirty flag
    // keeps it set, so that write is guaranteed a later frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dirty <= 1'b1;
        end else if (w_clear || w_a_grant || w_b_grant) begin
            r_dirty <= 1'b1;
        end else if (r_state == S_IDLE && r_dirty) begin
            r_dirty <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_dirty) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SEND;
            S_SEND:  if (send_done) w_state_nxt = S_DRAIN;
            // No new request while oled_control still holds send_done high.
            S_DRAIN: if (!send_done) w_state_nxt = w_last_idx ? S_IDLE : S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx           <= '0;
            send_data       <= '0;
            send_data_valid <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_dirty) begin
                        r_idx <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // Buffer is read here, so a write ahead of idx still
                    // makes it into the current frame.
                    send_data       <= r_buf[r_idx];
                    send_data_valid <= 1'b1;
                end
                S_SEND: begin
                    if (send_done) begin
                        send_data_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (!send_done) begin
                        if (w_last_idx) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
